serial_compare_scheduler: RTL

- Shares one MSB-first serial magnitude comparator (embedded 3-state FSM) between two parallel-word requesters.
- Round-robin arbiter grants one requester and latches its operand pair. A shift sequencer then feeds the comparator one bit pair per cycle, MSB first.
- Reports a one-cycle result pulse tagged with the requester id.
- Sits between parallel producers and the serial-comparison datapath of the sequential-basics block set.

---
 rtl/serial_compare_scheduler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/serial_compare_scheduler.sv
// Two-port round-robin front end sharing one MSB-first serial magnitude comparator.
// Each accepted operand pair is shifted out one bit pair per cycle; the result is a tagged one-cycle strobe.
module serial_compare_scheduler #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             busy,
   output logic             res_valid,
   output logic             res_id,
   output logic             res_a_less_b,
   output logic             res_a_eq_b,
   output logic             res_a_greater_b
);

   // state  | meaning
   // S_IDLE | arbitrate, accept one operand pair
   // S_SHIFT| feed one bit pair per cycle, MSB first
   // S_DONE | final comparator state valid, publish result
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} ctrl_e;
   typedef enum logic [1:0] {C_EQ, C_LT, C_GT} cmp_e;

   ctrl_e            ctrl_q, ctrl_d;
   cmp_e             cmp_q, cmp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic             id_q, id_d;
   logic             last_grant_q, last_grant_d;
   logic             res_valid_q, res_valid_d;
   logic             res_id_q, res_id_d;
   logic             res_lt_q, res_lt_d;
   logic             res_eq_q, res_eq_d;
   logic             res_gt_q, res_gt_d;

   logic             grant_vld;
   logic             grant_id;
   logic             accept;
   logic             sa;
   logic             sb;

   // Ties go to whichever requester was not served last.
   always_comb begin
      grant_vld = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant_id = ~last_grant_q;
      end else begin
         grant_id = req1_valid;
      end
      accept     = (ctrl_q == S_IDLE) & grant_vld;
      req0_ready = (ctrl_q == S_IDLE) & ~grant_id & req0_valid;
      req1_ready = (ctrl_q == S_IDLE) &  grant_id & req1_valid;
   end

   // Operands shift left, so the MSB position always holds the current bit pair.
   assign sa = a_sh_q[WIDTH-1];
   assign sb = b_sh_q[WIDTH-1];

   always_comb begin
      ctrl_d       = ctrl_q;
      cmp_d        = cmp_q;
      cnt_d        = cnt_q;
      a_sh_d       = a_sh_q;
      b_sh_d       = b_sh_q;
      id_d         = id_q;
      last_grant_d = last_grant_q;
      res_valid_d  = 1'b0;
      res_id_d     = res_id_q;
      res_lt_d     = res_lt_q;
      res_eq_d     = res_eq_q;
      res_gt_d     = res_gt_q;
      case (ctrl_q)
         S_IDLE: begin
            if (accept) begin
               a_sh_d       = grant_id ? req1_a : req0_a;
               b_sh_d       = grant_id ? req1_b : req0_b;
               id_d         = grant_id;
               last_grant_d = grant_id;
               cnt_d        = CW'(WIDTH - 1);
               cmp_d        = C_EQ;
               ctrl_d       = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (cmp_q == C_EQ) begin
               if (~sa & sb) begin
                  cmp_d = C_LT;
               end else if (sa & ~sb) begin
                  cmp_d = C_GT;
               end
            end
            a_sh_d = a_sh_q << 1;
            b_sh_d = b_sh_q << 1;
            if (cnt_q == '0) begin
               ctrl_d = S_DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE: begin
            res_valid_d = 1'b1;
            res_id_d    = id_q;
            res_lt_d    = (cmp_q == C_LT);
            res_eq_d    = (cmp_q == C_EQ);
            res_gt_d    = (cmp_q == C_GT);
            ctrl_d      = S_IDLE;
         end
         default: begin
            ctrl_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q       <= S_IDLE;
         cmp_q        <= C_EQ;
         cnt_q        <= '0;
         a_sh_q       <= '0;
         b_sh_q       <= '0;
         id_q         <= 1'b0;
         last_grant_q <= 1'b1;
         res_valid_q  <= 1'b0;
         res_id_q     <= 1'b0;
         res_lt_q     <= 1'b0;
         res_eq_q     <= 1'b0;
         res_gt_q     <= 1'b0;
      end else begin
         ctrl_q       <= ctrl_d;
         cmp_q        <= cmp_d;
         cnt_q        <= cnt_d;
         a_sh_q       <= a_sh_d;
         b_sh_q       <= b_sh_d;
         id_q         <= id_d;
         last_grant_q <= last_grant_d;
         res_valid_q  <= res_valid_d;
         res_id_q     <= res_id_d;
         res_lt_q     <= res_lt_d;
         res_eq_q     <= res_eq_d;
         res_gt_q     <= res_gt_d;
      end
   end

   assign busy            = (ctrl_q != S_IDLE);
   assign res_valid       = res_valid_q;
   assign res_id          = res_id_q;
   assign res_a_less_b    = res_lt_q;
   assign res_a_eq_b      = res_eq_q;
   assign res_a_greater_b = res_gt_q;

endmodule
